// File: rtl/digit_melody_seq.sv
// Plays a latched 4-digit BCD result as a note sequence: an optional sign tone,
// then one tone per digit starting at the first nonzero digit. Each note is followed by a gap.
module digit_melody_seq #(
  parameter int          NOTE_CYCLES = 8,
  parameter int          GAP_CYCLES  = 2,
  parameter logic [3:0]  SIGN_NOTE   = 4'hB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [3:0] num3,
  input  logic [3:0] num4,
  input  logic       sign,
  output logic [3:0] note,
  output logic       tone_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SIGN, PLAY, GAP, FIN} state_e;

  localparam logic [15:0] NOTE_LOAD = 16'(NOTE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [0:3][3:0]   digits_q, digits_d;
  logic              sign_q, sign_d;
  logic [3:0]        note_q, note_d;
  logic              tone_en_q, tone_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              playGo;
  logic [1:0]        playIdx;
  logic [1:0]        firstIdx;
  logic [3:0]        playDigit;
  logic [0:3][3:0]   srcDigits;

  always_comb begin
    if (num1 != 4'd0)      firstIdx = 2'd0;
    else if (num2 != 4'd0) firstIdx = 2'd1;
    else if (num3 != 4'd0) firstIdx = 2'd2;
    else                   firstIdx = 2'd3;
  end

  // idx_q always holds the index of the next digit to play; bit 2 set means none left.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    digits_d  = digits_q;
    sign_d    = sign_q;
    note_d    = 4'h0;
    tone_en_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    playGo    = 1'b0;
    playIdx   = idx_q[1:0];
    playDigit = 4'h0;
    srcDigits = digits_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !stop) begin
          digits_d  = {num1, num2, num3, num4};
          srcDigits = {num1, num2, num3, num4};
          sign_d    = sign;
          busy_d    = 1'b1;
          if (sign) begin
            state_d   = SIGN;
            cnt_d     = NOTE_LOAD;
            idx_d     = {1'b0, firstIdx};
            note_d    = SIGN_NOTE;
            tone_en_d = 1'b1;
          end else begin
            playGo  = 1'b1;
            playIdx = firstIdx;
          end
        end
      end
      SIGN: begin
        if (cnt_q != 16'd0) begin
          cnt_d     = cnt_q - 16'd1;
          note_d    = SIGN_NOTE;
          tone_en_d = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          playGo = 1'b1;
        end
      end
      PLAY: begin
        if (cnt_q != 16'd0) begin
          cnt_d     = cnt_q - 16'd1;
          note_d    = note_q;
          tone_en_d = tone_en_q;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else if (idx_q[2]) begin
          state_d = FIN;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          playGo = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (idx_q[2]) begin
          state_d = FIN;
          cnt_d   = 16'd0;
          done_d  = 1'b1;
        end else begin
          playGo = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        busy_d  = 1'b0;
      end
    endcase

    // Invalid BCD digits keep their time slot but stay silent.
    if (playGo) begin
      state_d   = PLAY;
      cnt_d     = NOTE_LOAD;
      idx_d     = {1'b0, playIdx} + 3'd1;
      playDigit = srcDigits[playIdx];
      if (playDigit <= 4'd9) begin
        note_d    = playDigit;
        tone_en_d = 1'b1;
      end
    end

    if (stop && (state_q != IDLE)) begin
      state_d   = IDLE;
      cnt_d     = 16'd0;
      idx_d     = 3'd0;
      note_d    = 4'h0;
      tone_en_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      digits_q  <= '0;
      sign_q    <= 1'b0;
      note_q    <= 4'h0;
      tone_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      digits_q  <= digits_d;
      sign_q    <= sign_d;
      note_q    <= note_d;
      tone_en_q <= tone_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign note    = note_q;
  assign tone_en = tone_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_digit_melody_seq.sv
// Scoreboard bench for digit_melody_seq: a per-cycle reference of {busy,done,tone_en,note}
// is queued when a sequence is launched and popped each cycle against the DUT outputs.
module tb_digit_melody_seq;

  localparam int         NOTE = 4;
  localparam int         GAP  = 2;
  localparam logic [3:0] SN   = 4'hB;

  logic       clk = 1'b0;
  logic       reset, start, stop, sign;
  logic [3:0] num1, num2, num3, num4;
  logic [3:0] note;
  logic       tone_en, busy, done;

  int assertCount = 0;
  int failCount   = 0;

  logic [6:0] expQ[$];

  digit_melody_seq #(
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP),
    .SIGN_NOTE  (SN)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stop   (stop),
    .num1   (num1),
    .num2   (num2),
    .num3   (num3),
    .num4   (num4),
    .sign   (sign),
    .note   (note),
    .tone_en(tone_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: busy/done/tone_en/note got %b/%b/%b/%h, expected %b/%b/%b/%h",
               tag, observed[6], observed[5], observed[4], observed[3:0],
               expected[6], expected[5], expected[4], expected[3:0]);
    end
  endtask

  function automatic void pushSlot(input logic [3:0] d, input logic en);
    for (int i = 0; i < NOTE; i++) expQ.push_back({1'b1, 1'b0, en, (en ? d : 4'h0)});
    for (int i = 0; i < GAP; i++)  expQ.push_back(7'b100_0000);
  endfunction

  // Launches one sequence; optional extra start pulses, stop or reset in a given cycle (0 = none).
  task automatic applyStimulus(input string name, input logic [3:0] d1, input logic [3:0] d2,
                               input logic [3:0] d3, input logic [3:0] d4, input logic s,
                               input int pulseA, input int pulseB, input int stopAt, input int resetAt);
    logic [3:0] digs[4];
    int         first;
    int         cut;
    logic [6:0] expv;
    expQ.delete();
    digs[0] = d1; digs[1] = d2; digs[2] = d3; digs[3] = d4;
    first = 3;
    for (int i = 2; i >= 0; i--) if (digs[i] != 4'd0) first = i;
    if (s) pushSlot(SN, 1'b1);
    for (int i = first; i < 4; i++) pushSlot(digs[i], digs[i] <= 4'd9);
    expQ.push_back(7'b110_0000);
    expQ.push_back(7'b000_0000);
    expQ.push_back(7'b000_0000);
    cut = (stopAt > 0) ? stopAt : resetAt;
    if (cut > 0 && cut < expQ.size()) begin
      while (expQ.size() > cut) void'(expQ.pop_back());
      expQ.push_back(7'b000_0000);
    end

    num1 = d1; num2 = d2; num3 = d3; num4 = d4; sign = s;
    start = 1'b1; stop = 1'b0; reset = 1'b0;
    @(negedge clk);
    for (int k = 1; expQ.size() > 0; k++) begin
      expv = expQ.pop_front();
      checkOutput($sformatf("%s c%0d", name, k), {busy, done, tone_en, note}, expv);
      start = (k == pulseA) || (k == pulseB);
      stop  = (k == stopAt);
      reset = (k == resetAt);
      if (k == 2) begin
        num1 = 4'($urandom); num2 = 4'($urandom);
        num3 = 4'($urandom); num4 = 4'($urandom);
        sign = ~s;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; sign = 1'b0;
    num1 = 4'd0; num2 = 4'd0; num3 = 4'd0; num4 = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset", {busy, done, tone_en, note}, 7'b000_0000);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle", {busy, done, tone_en, note}, 7'b000_0000);

    // stop and start together in IDLE: start is dropped
    num3 = 4'd4; num4 = 4'd2;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checkOutput("stopstart c1", {busy, done, tone_en, note}, 7'b000_0000);
    @(negedge clk);
    checkOutput("stopstart c2", {busy, done, tone_en, note}, 7'b000_0000);

    applyStimulus("s1_0042",    4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 0, 0, 0, 0);
    applyStimulus("s2_0000",    4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0, 0, 0);
    applyStimulus("s3_neg7",    4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 0, 0, 0, 0);
    applyStimulus("s4_1C34",    4'd1, 4'hC, 4'd3, 4'd4, 1'b0, 0, 0, 0, 0);
    applyStimulus("s5_stop",    4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 0, 0, 3, 0);
    applyStimulus("s5_restart", 4'd9, 4'd0, 4'd0, 4'd5, 1'b1, 0, 0, 0, 0);
    applyStimulus("s6_repulse", 4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 2, 13, 0, 0);
    applyStimulus("s6_reset",   4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 0, 0, 0, 8);
    applyStimulus("neg_FFFF",   4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/digit_melody_seq.md
Name: digit_melody_seq

Overview:
- Sequencer that plays the calculator result as a melody: one tone per digit of the 4-digit display value, plus a leading sign tone for negative results.
- Sits between the control unit outputs (num1..num4, sign) and the tone generator/buzzer driver.
- Owns note timing, gaps, leading-zero suppression and abort.
- The tone generator only sees a note code and an enable.

Parameters:
- NOTE_CYCLES, 8, clock cycles a note is sounded; range 1..65535.
- GAP_CYCLES, 2, silent cycles after every note; range 0..65535, 0 = back-to-back notes.
- SIGN_NOTE, 4'hB, note code emitted for the minus sign.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request playback; sampled every cycle, honoured only when busy=0
- stop  in  1  abort playback
- num1  in  4  most significant BCD digit
- num2  in  4  BCD digit
- num3  in  4  BCD digit
- num4  in  4  least significant BCD digit
- sign  in  1  1 = negative result
- note  out  4  note code to tone generator; digit value, or SIGN_NOTE
- tone_en  out  1  tone generator enable
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when a sequence completes normally

Behaviour:
- Reset values: note=0, tone_en=0, busy=0, done=0, state IDLE, counters 0.
- Reset has priority over all other inputs. Reset mid-sequence returns to IDLE on the next edge with no done pulse.
- States: IDLE, SIGN, PLAY, GAP, FIN.
- IDLE:
  - start=1 at edge T latches num1..num4 and sign into internal registers. Later input changes are ignored until the next start.
  - Leading-zero suppression: playback begins at the first nonzero digit among num1..num3. num4 is always played, so 0000 plays one note "0".
  - Next state is SIGN if latched sign=1, else PLAY.
  - busy=1 from T+1.
- SIGN:
  - note=SIGN_NOTE, tone_en=1 for NOTE_CYCLES cycles.
  - Then GAP, or straight to the first PLAY if GAP_CYCLES=0.
- PLAY:
  - note=current digit, tone_en=1 for NOTE_CYCLES cycles.
  - Invalid BCD digit (>9): the slot is kept with identical timing, but tone_en=0 and note=0.
- GAP:
  - note=0, tone_en=0 for GAP_CYCLES cycles.
  - Then advance to the next digit (PLAY), or to FIN after num4.
  - With GAP_CYCLES=0 the GAP state is skipped entirely.
- FIN: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- start while busy=1 (including the FIN cycle) is ignored and not queued.
- stop=1 in any non-IDLE state:
  - Next cycle: IDLE, tone_en=0, note=0, busy=0, no done.
  - stop in IDLE has no effect.
  - stop and start in the same IDLE cycle: stop wins, start is dropped.
- Timing per played note is NOTE_CYCLES + GAP_CYCLES cycles.
- Total busy cycles = N*(NOTE_CYCLES+GAP_CYCLES) + 1, where N = played digits + sign.
- Duration counter is 16 bits and reloads on every state entry. No wrap is possible within the legal parameter range.
- note and tone_en are registered outputs; no combinational path from inputs to outputs.

Test Plan (NOTE_CYCLES=4, GAP_CYCLES=2, start pulsed at edge T):
1. num=0,0,4,2, sign=0 -> tone_en=1 note=4 at T+1..T+4; silent T+5..T+6; note=2 at T+7..T+10; silent T+11..T+12; done=1 at T+13; busy=1 at T+1..T+13, busy=0 at T+14.
2. num=0,0,0,0 -> single note 0 at T+1..T+4; silent T+5..T+6; done at T+7.
3. num=0,0,0,7, sign=1 -> note=B at T+1..T+4; gap; note=7 at T+7..T+10; done at T+13.
4. num=1,C,3,4 -> slot 2 (T+7..T+10) has tone_en=0 with other slots unchanged; done at T+25.
5. stop at T+3 during the first note -> at T+4: tone_en=0, busy=0; done never asserted. A new start at T+5 is accepted.
6. start re-pulsed at T+2 and T+13 -> ignored, sequence identical to scenario 1. reset at T+8 -> all outputs at reset values from T+9, no done.
